// File: rtl/mm_stage_pkg.sv
// Shared definitions for the matching-memory stage: LR encoding, output
// buffer states and the per-packet action classification.
package mm_stage_pkg;

  localparam logic LR_L = 1'b0;
  localparam logic LR_R = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  typedef enum logic [2:0] {
    ACT_IDLE    = 3'd0,
    ACT_MONO    = 3'd1,
    ACT_STORE   = 3'd2,
    ACT_PAIR    = 3'd3,
    ACT_COLLIDE = 3'd4
  } action_e;

  // Decide what an accepted packet does, given the table entry it indexes.
  function automatic action_e classify(input logic mono, input logic hit,
                                       input logic stored_lr, input logic lr);
    if (mono)             return ACT_MONO;
    if (!hit)             return ACT_STORE;
    if (stored_lr != lr)  return ACT_PAIR;
    return ACT_COLLIDE;
  endfunction

endpackage

// File: rtl/mm_stage_table.sv
// Waiting-operand table: one {valid, lr, data} entry per {CG, DEST},
// combinational lookup, single store/clear port and an occupancy counter.
module mm_stage_table
  import mm_stage_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx,
  output logic              hit,
  output logic              hit_lr,
  output logic [DATA_W-1:0] hit_data,
  input  logic              store,
  input  logic              store_lr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              clear,
  output logic [IDX_W:0]    occ
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  lr;
  logic [DATA_W-1:0] data [DEPTH];

  assign hit      = valid[idx];
  assign hit_lr   = lr[idx];
  assign hit_data = data[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (store) begin
      valid[idx] <= 1'b1;
    end else if (clear) begin
      valid[idx] <= 1'b0;
    end
  end

  // Payload needs no reset: it is only ever read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (store) begin
      lr[idx]   <= store_lr;
      data[idx] <= store_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else if (store) begin
      occ <= occ + (IDX_W+1)'(1);
    end else if (clear) begin
      occ <= occ - (IDX_W+1)'(1);
    end
  end

endmodule

// File: rtl/mm_stage.sv
// Matching-memory stage: pairs dyadic operands by {CG, DEST}, forwards
// monadic packets, and holds one fired packet for the PS stage.
module mm_stage
  import mm_stage_pkg::*;
#(
  parameter int CG_W   = 4,
  parameter int DEST_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                           CP,
  input  logic                           MR,
  input  logic                           Send_in,
  output logic                           Ack_out,
  input  logic [CG_W+DEST_W+2+DATA_W-1:0] PACKET_IN,
  output logic                           Send_out,
  input  logic                           Ack_in,
  output logic [CG_W+DEST_W+2*DATA_W-1:0] PACKET_OUT,
  output logic [CG_W+DEST_W:0]           OCC,
  output logic                           COLL
);

  localparam int IDX_W = CG_W + DEST_W;
  localparam int OUT_W = IDX_W + 2*DATA_W;

  // {CG, DEST} are adjacent, so together they form the table index.
  logic [IDX_W-1:0]  in_idx;
  logic              in_mono;
  logic              in_lr;
  logic [DATA_W-1:0] in_data;

  assign in_idx  = PACKET_IN[IDX_W+2+DATA_W-1 -: IDX_W];
  assign in_mono = PACKET_IN[DATA_W+1];
  assign in_lr   = PACKET_IN[DATA_W];
  assign in_data = PACKET_IN[DATA_W-1:0];

  out_state_e        state;
  out_state_e        state_next;
  action_e           act;
  logic              accept;
  logic              drain;
  logic              fire;
  logic [OUT_W-1:0]  fire_pkt;
  logic              hit;
  logic              hit_lr;
  logic [DATA_W-1:0] hit_data;

  mm_stage_table #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_table (
    .clk        (CP),
    .reset      (MR),
    .idx        (in_idx),
    .hit        (hit),
    .hit_lr     (hit_lr),
    .hit_data   (hit_data),
    .store      (act == ACT_STORE),
    .store_lr   (in_lr),
    .store_data (in_data),
    .clear      (act == ACT_PAIR),
    .occ        (OCC)
  );

  assign Send_out = (state == OUT_FULL);
  assign Ack_out  = !Send_out || Ack_in;
  assign accept   = Send_in && Ack_out;
  assign drain    = Send_out && Ack_in;

  always_comb begin
    act = ACT_IDLE;
    if (accept) begin
      act = classify(in_mono, hit, hit_lr, in_lr);
    end
  end

  assign fire = (act == ACT_MONO) || (act == ACT_PAIR);

  // The operand with LR=L always lands in DATA_L, whichever arrived first.
  always_comb begin
    fire_pkt = {in_idx, in_data, {DATA_W{1'b0}}};
    if (act == ACT_PAIR) begin
      if (in_lr == LR_L) begin
        fire_pkt = {in_idx, in_data, hit_data};
      end else begin
        fire_pkt = {in_idx, hit_data, in_data};
      end
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (fire) begin
      state_next = OUT_FULL;
    end else if (drain) begin
      state_next = OUT_EMPTY;
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      PACKET_OUT <= '0;
    end else if (fire) begin
      PACKET_OUT <= fire_pkt;
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      COLL <= 1'b0;
    end else if (act == ACT_COLLIDE) begin
      COLL <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mm_stage.sv
// Self-checking bench for mm_stage: directed scenarios plus randomized
// traffic against a queue/array reference model of the matching rules.
module tb_mm_stage;

  localparam int CG_W   = 4;
  localparam int DEST_W = 4;
  localparam int DATA_W = 16;
  localparam int IDX_W  = CG_W + DEST_W;
  localparam int IN_W   = IDX_W + 2 + DATA_W;
  localparam int OUT_W  = IDX_W + 2*DATA_W;
  localparam int DEPTH  = 1 << IDX_W;

  logic             CP = 1'b0;
  logic             MR;
  logic             Send_in;
  logic             Ack_out;
  logic [IN_W-1:0]  PACKET_IN;
  logic             Send_out;
  logic             Ack_in;
  logic [OUT_W-1:0] PACKET_OUT;
  logic [IDX_W:0]   OCC;
  logic             COLL;

  mm_stage #(.CG_W(CG_W), .DEST_W(DEST_W), .DATA_W(DATA_W)) dut (
    .CP         (CP),
    .MR         (MR),
    .Send_in    (Send_in),
    .Ack_out    (Ack_out),
    .PACKET_IN  (PACKET_IN),
    .Send_out   (Send_out),
    .Ack_in     (Ack_in),
    .PACKET_OUT (PACKET_OUT),
    .OCC        (OCC),
    .COLL       (COLL)
  );

  always #5 CP = ~CP;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: waiting operands per {CG, DEST} and fired packets in order.
  bit               m_valid [DEPTH];
  bit               m_lr    [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  int               m_occ;
  bit               m_coll;
  logic [OUT_W-1:0] m_q [$];
  logic             seen_ack;
  logic             exp_ack;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_q.delete();
    m_occ  = 0;
    m_coll = 1'b0;
  endtask

  task automatic drive_cycle(input logic s, input logic [CG_W-1:0] cg,
                             input logic [DEST_W-1:0] dest, input logic mono,
                             input logic lr, input logic [DATA_W-1:0] data,
                             input logic ack);
    int idx;
    logic [DATA_W-1:0] dl;
    logic [DATA_W-1:0] dr;
    Send_in   = s;
    PACKET_IN = {cg, dest, mono, lr, data};
    Ack_in    = ack;
    #1;
    seen_ack = Ack_out;
    exp_ack  = (m_q.size() == 0) || ack;
    if (m_q.size() != 0 && ack) void'(m_q.pop_front());
    if (s && exp_ack) begin
      idx = int'({cg, dest});
      if (mono) begin
        m_q.push_back({cg, dest, data, {DATA_W{1'b0}}});
      end else if (!m_valid[idx]) begin
        m_valid[idx] = 1'b1;
        m_lr[idx]    = lr;
        m_data[idx]  = data;
        m_occ++;
      end else if (m_lr[idx] != lr) begin
        dl = lr ? m_data[idx] : data;
        dr = lr ? data : m_data[idx];
        m_q.push_back({cg, dest, dl, dr});
        m_valid[idx] = 1'b0;
        m_occ--;
      end else begin
        m_coll = 1'b1;
      end
    end
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    MR        = 1'b1;
    Send_in   = 1'b0;
    Ack_in    = 1'b0;
    PACKET_IN = '0;
    @(posedge CP);
    #1;
    MR = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++;
    if (Send_out !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %0b want 0", Send_out); end
    n_checks++;
    if (OCC !== '0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", OCC); end
    n_checks++;
    if (COLL !== 1'b0) begin n_fail++; $display("FAIL reset_coll: got %0b want 0", COLL); end
    n_checks++;
    if (seen_ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack: got %0b want 1", seen_ack); end
    n_checks++;
    if (PACKET_OUT !== '0) begin n_fail++; $display("FAIL reset_pkt: got %h want 0", PACKET_OUT); end
  endtask

  task automatic test_monadic();
    do_reset();
    drive_cycle(1'b1, 4'd1, 4'd3, 1'b1, 1'b0, 16'h0042, 1'b1);
    n_checks++;
    if (Send_out !== 1'b1) begin n_fail++; $display("FAIL mono_send: got %0b want 1", Send_out); end
    n_checks++;
    if (PACKET_OUT !== 40'h13_0042_0000) begin
      n_fail++; $display("FAIL mono_pkt: got %h want 1300420000", PACKET_OUT);
    end
    n_checks++;
    if (OCC !== 9'd0) begin n_fail++; $display("FAIL mono_occ: got %0d want 0", OCC); end
    drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++;
    if (Send_out !== 1'b0) begin n_fail++; $display("FAIL mono_drain: got %0b want 0", Send_out); end
  endtask

  task automatic test_pair();
    do_reset();
    drive_cycle(1'b1, 4'd2, 4'd5, 1'b0, 1'b1, 16'h0007, 1'b1);
    n_checks++;
    if (Send_out !== 1'b0) begin n_fail++; $display("FAIL pair_store_send: got %0b want 0", Send_out); end
    n_checks++;
    if (OCC !== 9'd1) begin n_fail++; $display("FAIL pair_store_occ: got %0d want 1", OCC); end
    drive_cycle(1'b1, 4'd2, 4'd5, 1'b0, 1'b0, 16'h0003, 1'b1);
    n_checks++;
    if (PACKET_OUT !== 40'h25_0003_0007 || Send_out !== 1'b1) begin
      n_fail++; $display("FAIL pair_fire: got send=%0b pkt=%h want send=1 pkt=2500030007", Send_out, PACKET_OUT);
    end
    n_checks++;
    if (OCC !== 9'd0) begin n_fail++; $display("FAIL pair_occ: got %0d want 0", OCC); end
  endtask

  task automatic test_cg_distinct();
    do_reset();
    drive_cycle(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 16'h0011, 1'b1);
    drive_cycle(1'b1, 4'd1, 4'd5, 1'b0, 1'b0, 16'h0022, 1'b1);
    n_checks++;
    if (OCC !== 9'd2 || Send_out !== 1'b0) begin
      n_fail++; $display("FAIL cg_store: got occ=%0d send=%0b want occ=2 send=0", OCC, Send_out);
    end
    drive_cycle(1'b1, 4'd1, 4'd5, 1'b0, 1'b1, 16'h0033, 1'b1);
    n_checks++;
    if (PACKET_OUT !== 40'h15_0022_0033 || Send_out !== 1'b1) begin
      n_fail++; $display("FAIL cg_fire: got send=%0b pkt=%h want send=1 pkt=1500220033", Send_out, PACKET_OUT);
    end
    n_checks++;
    if (OCC !== 9'd1) begin n_fail++; $display("FAIL cg_occ: got %0d want 1", OCC); end
  endtask

  task automatic test_collision();
    do_reset();
    drive_cycle(1'b1, 4'd0, 4'd9, 1'b0, 1'b0, 16'h00A1, 1'b1);
    drive_cycle(1'b1, 4'd0, 4'd9, 1'b0, 1'b0, 16'h00B2, 1'b1);
    n_checks++;
    if (COLL !== 1'b1) begin n_fail++; $display("FAIL coll_flag: got %0b want 1", COLL); end
    n_checks++;
    if (OCC !== 9'd1 || Send_out !== 1'b0) begin
      n_fail++; $display("FAIL coll_occ: got occ=%0d send=%0b want occ=1 send=0", OCC, Send_out);
    end
    drive_cycle(1'b1, 4'd0, 4'd9, 1'b0, 1'b1, 16'h00C3, 1'b1);
    n_checks++;
    if (PACKET_OUT !== 40'h09_00A1_00C3 || Send_out !== 1'b1) begin
      n_fail++; $display("FAIL coll_pair: got send=%0b pkt=%h want send=1 pkt=0900a100c3", Send_out, PACKET_OUT);
    end
    n_checks++;
    if (COLL !== 1'b1 || OCC !== 9'd0) begin
      n_fail++; $display("FAIL coll_sticky: got coll=%0b occ=%0d want coll=1 occ=0", COLL, OCC);
    end
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    drive_cycle(1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 16'h0099, 1'b1);
    drive_cycle(1'b1, 4'd3, 4'd4, 1'b1, 1'b0, 16'h0055, 1'b0);
    drive_cycle(1'b1, 4'd5, 4'd6, 1'b1, 1'b0, 16'h0066, 1'b0);
    n_checks++;
    if (seen_ack !== 1'b0) begin n_fail++; $display("FAIL bp_ack: got %0b want 0", seen_ack); end
    n_checks++;
    if (PACKET_OUT !== 40'h34_0055_0000 || Send_out !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got send=%0b pkt=%h want send=1 pkt=3400550000", Send_out, PACKET_OUT);
    end
    MR = 1'b1;
    @(posedge CP);
    #1;
    n_checks++;
    if (Send_out !== 1'b0 || OCC !== '0 || PACKET_OUT !== '0) begin
      n_fail++; $display("FAIL mid_reset: got send=%0b occ=%0d pkt=%h want 0 0 0", Send_out, OCC, PACKET_OUT);
    end
    MR      = 1'b0;
    Send_in = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (Ack_out !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ack: got %0b want 1", Ack_out); end
    drive_cycle(1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 16'h0001, 1'b1);
    n_checks++;
    if (Send_out !== 1'b0 || OCC !== 9'd1) begin
      n_fail++; $display("FAIL table_cleared: got send=%0b occ=%0d want send=0 occ=1", Send_out, OCC);
    end
  endtask

  task automatic test_random();
    logic s, mono, lr, ack;
    logic [CG_W-1:0] cg;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      s    = ($urandom_range(0, 3) != 0);
      cg   = CG_W'($urandom_range(0, 1));
      dest = DEST_W'($urandom_range(0, 3));
      mono = ($urandom_range(0, 4) == 0);
      lr   = 1'($urandom_range(0, 1));
      data = DATA_W'($urandom);
      ack  = ($urandom_range(0, 3) != 0);
      drive_cycle(s, cg, dest, mono, lr, data, ack);
      n_checks++;
      if (seen_ack !== exp_ack) begin
        n_fail++; $display("FAIL rnd_ack[%0d]: got %0b want %0b", n, seen_ack, exp_ack);
      end
      n_checks++;
      if (Send_out !== (m_q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_send[%0d]: got %0b want %0b", n, Send_out, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        n_checks++;
        if (PACKET_OUT !== m_q[0]) begin
          n_fail++; $display("FAIL rnd_pkt[%0d]: got %h want %h", n, PACKET_OUT, m_q[0]);
        end
      end
      n_checks++;
      if (OCC !== (IDX_W+1)'(m_occ) || COLL !== m_coll) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got occ=%0d coll=%0b want occ=%0d coll=%0b",
                           n, OCC, COLL, m_occ, m_coll);
      end
    end
  endtask

  initial begin
    MR        = 1'b1;
    Send_in   = 1'b0;
    Ack_in    = 1'b0;
    PACKET_IN = '0;
    model_reset();
    @(posedge CP);
    #1;
    test_reset();
    test_monadic();
    test_pair();
    test_cg_distinct();
    test_collision();
    test_backpressure_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
